mpu6050_seq: RTL and testbench

Register-sequencing controller placed between the top level and the single-byte IIC master. After reset it waits for sensor power-up, optionally verifies WHO_AM_I, and writes a fixed init table. It then periodically burst-reads the 14 accel/temp/gyro registers (0x3B–0x48) one byte per transaction, assembles seven signed 16-bit words, and publishes them atomically with a one-cycle valid strobe.

---
 rtl/mpu6050_seq.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mpu6050_seq.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_seq.sv
// MPU-6050 register sequencer: power-up wait, init table, then periodic 14-byte sample bursts.
// Optional WHO_AM_I read before init is compiled in with `define MPU_WHOAMI_CHECK_EN.
module mpu6050_seq #(
    parameter int         SYS_CLOCK   = 20_000_000,
    parameter int         SAMPLE_HZ   = 100,
    parameter int         POWERUP_CYC = 2_000_000,
    parameter int         TIMEOUT_CYC = 8192,
    parameter logic [2:0] CS_BIT      = 3'b000
) (
    input  logic        clk50M,
    input  logic        reset,
    output logic        iic_en,
    output logic        write,
    output logic        read,
    output logic [2:0]  cs_bit,
    output logic [7:0]  address,
    output logic [7:0]  write_data,
    input  logic [7:0]  read_data,
    input  logic        done,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy,
    output logic        error
);
    localparam int SAMPLE_DIV = SYS_CLOCK / SAMPLE_HZ;
    localparam int PW         = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;

    typedef enum logic [2:0] {
        S_PWRUP, S_WHOAMI, S_INIT, S_WAIT_TICK, S_READ, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          wait_q, wait_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [12:0]   tmo_q, tmo_d;
    logic [1:0]    retry_q, retry_d;
    logic [17:0]   tick_q, tick_d;
    logic          pend_q, pend_d;
    logic [15:0]   shadow_q [7];
    logic [15:0]   shadow_d [7];
    logic [15:0]   words_q [7];
    logic [15:0]   words_d [7];
    logic          iic_en_q, iic_en_d, write_q, write_d, read_q, read_d;
    logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic          sv_q, sv_d, initd_q, initd_d, busy_q, busy_d, err_q, err_d;

    logic          issue, iss_wr, got_done, tick;
    logic [7:0]    iss_addr, iss_data;

    function automatic logic [15:0] init_entry(input logic [3:0] i);
        case (i)
            4'd0:    init_entry = 16'h6B00;
            4'd1:    init_entry = 16'h1907;
            4'd2:    init_entry = 16'h1A06;
            4'd3:    init_entry = 16'h1B18;
            default: init_entry = 16'h1C00;
        endcase
    endfunction

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q  <= S_PWRUP;
            wait_q   <= 1'b0;
            idx_q    <= '0;
            pwr_q    <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            tick_q   <= '0;
            pend_q   <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                shadow_q[i] <= '0;
                words_q[i]  <= '0;
            end
            iic_en_q <= 1'b0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sv_q     <= 1'b0;
            initd_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            pwr_q    <= pwr_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            words_q  <= words_d;
            iic_en_q <= iic_en_d;
            write_q  <= write_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sv_q     <= sv_d;
            initd_q  <= initd_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        pwr_d    = pwr_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        shadow_d = shadow_q;
        words_d  = words_q;
        iic_en_d = 1'b0;
        write_d  = 1'b0;
        read_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sv_d     = 1'b0;
        initd_d  = initd_q;
        busy_d   = busy_q;
        err_d    = err_q;
        issue    = 1'b0;
        iss_wr   = 1'b0;
        iss_addr = addr_q;
        iss_data = wdata_q;
        got_done = 1'b0;
        pend_d   = pend_q;
        tick     = initd_q && (tick_q == 18'(SAMPLE_DIV - 1));
        tick_d   = (initd_q && !tick) ? tick_q + 18'd1 : 18'd0;

        // A timed-out attempt drops back to the issue sub-phase with idx unchanged, so it is reissued.
        if (wait_q) begin
            if (done) begin
                got_done = 1'b1;
                wait_d   = 1'b0;
                busy_d   = 1'b0;
                retry_d  = '0;
            end else if (tmo_q == 13'(TIMEOUT_CYC - 1)) begin
                wait_d = 1'b0;
                busy_d = 1'b0;
                if (retry_q == 2'd3) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    retry_d = retry_q + 2'd1;
                end
            end else begin
                tmo_d = tmo_q + 13'd1;
            end
        end

        case (state_q)
            S_PWRUP: begin
                if (pwr_q == PW'(POWERUP_CYC - 1)) begin
                    pwr_d   = '0;
                    idx_d   = '0;
                    wait_d  = 1'b0;
                    retry_d = '0;
`ifdef MPU_WHOAMI_CHECK_EN
                    state_d = S_WHOAMI;
`else
                    state_d = S_INIT;
`endif
                end else begin
                    pwr_d = pwr_q + 1'b1;
                end
            end
`ifdef MPU_WHOAMI_CHECK_EN
            S_WHOAMI: begin
                if (!wait_q) begin
                    issue    = 1'b1;
                    iss_addr = 8'h75;
                end else if (got_done) begin
                    if (read_data != 8'h68) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_INIT;
                        idx_d   = '0;
                    end
                end
            end
`endif
            S_INIT: begin
                if (!wait_q) begin
                    issue    = 1'b1;
                    iss_wr   = 1'b1;
                    iss_addr = init_entry(idx_q)[15:8];
                    iss_data = init_entry(idx_q)[7:0];
                end else if (got_done) begin
                    if (idx_q == 4'd4) begin
                        initd_d = 1'b1;
                        state_d = S_WAIT_TICK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_WAIT_TICK: begin
                if (pend_q) begin
                    pend_d   = 1'b0;
                    state_d  = S_READ;
                    idx_d    = '0;
                    issue    = 1'b1;
                    iss_addr = 8'h3B;
                end
            end
            S_READ: begin
                if (!wait_q) begin
                    issue    = 1'b1;
                    iss_addr = 8'h3B + {4'd0, idx_q};
                end else if (got_done) begin
                    if (!idx_q[0]) shadow_d[idx_q[3:1]][15:8] = read_data;
                    else           shadow_d[idx_q[3:1]][7:0]  = read_data;
                    if (idx_q == 4'd13) begin
                        words_d = shadow_d;
                        sv_d    = 1'b1;
                        state_d = S_WAIT_TICK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_ERROR: begin
            end
            default: begin
                state_d = S_ERROR;
                err_d   = 1'b1;
            end
        endcase

        if (tick) pend_d = 1'b1;

        if (issue) begin
            iic_en_d = 1'b1;
            write_d  = iss_wr;
            read_d   = !iss_wr;
            addr_d   = iss_addr;
            wdata_d  = iss_data;
            busy_d   = 1'b1;
            wait_d   = 1'b1;
            tmo_d    = '0;
        end
    end

    assign iic_en       = iic_en_q;
    assign write        = write_q;
    assign read         = read_q;
    assign cs_bit       = CS_BIT;
    assign address      = addr_q;
    assign write_data   = wdata_q;
    assign accel_x      = words_q[0];
    assign accel_y      = words_q[1];
    assign accel_z      = words_q[2];
    assign temp         = words_q[3];
    assign gyro_x       = words_q[4];
    assign gyro_y       = words_q[5];
    assign gyro_z       = words_q[6];
    assign sample_valid = sv_q;
    assign init_done    = initd_q;
    assign busy         = busy_q;
    assign error        = err_q;
endmodule

// File: tb/tb_mpu6050_seq.sv
// Bench for mpu6050_seq: behavioural IIC slave with a register memory, fault injection and
// scenario tasks comparing DUT outputs against values derived from the register map.
module tb_mpu6050_seq;
    localparam int SYS_CLOCK = 4000;
    localparam int SAMPLE_HZ = 10;
    localparam int DIV       = SYS_CLOCK / SAMPLE_HZ;
    localparam int PUP       = 50;
    localparam int TMO       = 40;
`ifdef MPU_WHOAMI_CHECK_EN
    localparam int NW = 1;
`else
    localparam int NW = 0;
`endif

    logic        clk50M, reset;
    logic        iic_en, write, read, done, sample_valid, init_done, busy, error;
    logic [2:0]  cs_bit;
    logic [7:0]  address, write_data, read_data;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;

    mpu6050_seq #(
        .SYS_CLOCK(SYS_CLOCK), .SAMPLE_HZ(SAMPLE_HZ), .POWERUP_CYC(PUP),
        .TIMEOUT_CYC(TMO), .CS_BIT(3'b000)
    ) dut (
        .clk50M(clk50M), .reset(reset), .iic_en(iic_en), .write(write), .read(read),
        .cs_bit(cs_bit), .address(address), .write_data(write_data), .read_data(read_data),
        .done(done), .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z), .sample_valid(sample_valid),
        .init_done(init_done), .busy(busy), .error(error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         last_done_cyc = -10;
    int         sv_count = 0;
    int         resp_left = 0;
    logic [7:0] resp_byte;
    logic       prev_en = 1'b0;
    logic [7:0] fail_addr = 8'h00;
    int         fail_left = 0;
    logic [7:0] whoami_val = 8'h68;
    bit         addr_mode = 1'b1;
    bit         rand_lat = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    bit         log_wr [$];
    int         log_cyc [$];
    int         sv_cyc [$];

    initial clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // IIC slave model: answers each accepted command after a latency, or withholds done to fake a NACK.
    initial begin
        done = 1'b0;
        read_data = 8'h00;
        forever begin
            bit pend;
            @(posedge clk50M);
            #1;
            cyc++;
            done = 1'b0;
            pend = (resp_left > 0);
            if (sample_valid === 1'b1) begin
                sv_count++;
                sv_cyc.push_back(cyc);
            end
            if (resp_left > 0) begin
                resp_left--;
                if (resp_left == 0) begin
                    done = 1'b1;
                    read_data = resp_byte;
                    last_done_cyc = cyc;
                end
            end
            if (iic_en === 1'b1) begin
                n_checks++;
                if ((write ^ read) !== 1'b1 || prev_en || pend || busy !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL protocol at cycle %0d: wr=%b rd=%b prev_en=%b pend=%b busy=%b required wr^rd=1 prev_en=0 pend=0 busy=1",
                             cyc, write, read, prev_en, pend, busy);
                end
                log_addr.push_back(address);
                log_data.push_back(write_data);
                log_wr.push_back(write);
                log_cyc.push_back(cyc);
                if (address == fail_addr && fail_left > 0) begin
                    if (fail_left != 255) fail_left--;
                end else begin
                    resp_left = rand_lat ? int'($urandom_range(1, 6)) : 3;
                    if (address == 8'h75)  resp_byte = whoami_val;
                    else if (addr_mode)    resp_byte = address;
                    else                   resp_byte = mem[address];
                end
            end
            prev_en = (iic_en === 1'b1);
        end
    end

    task automatic step();
        @(posedge clk50M);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
        log_cyc.delete();
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        int rel;
        reset = 1'b1;
        steps(3);
        n_checks++;
        if ({iic_en, write, read, sample_valid, init_done, busy, error} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b required 0000000", {iic_en, write, read, sample_valid, init_done, busy, error});
        end
        n_checks++;
        if ({address, write_data} !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got %h required 0000", {address, write_data});
        end
        n_checks++;
        if (cs_bit !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_cs: got %b required 000", cs_bit);
        end
        n_checks++;
        if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_words: got %h required 0", {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z});
        end
        clear_log();
        rel = cyc;
        reset = 1'b0;
        for (int k = 0; k < PUP + 20 && log_addr.size() == 0; k++) step();
        n_checks++;
        if (log_addr.size() == 0 || log_cyc[0] - rel < PUP || log_cyc[0] - rel > PUP + 3) begin
            n_fail++;
            $display("[TB] FAIL powerup_delay: got %0d cycles (entries %0d) required %0d..%0d",
                     log_addr.size() ? log_cyc[0] - rel : -1, log_addr.size(), PUP, PUP + 3);
        end
    endtask

    task automatic test_init();
        logic [7:0] ea [5] = '{8'h6B, 8'h19, 8'h1A, 8'h1B, 8'h1C};
        logic [7:0] ed [5] = '{8'h00, 8'h07, 8'h06, 8'h18, 8'h00};
        for (int k = 0; k < 200 && log_addr.size() < 5 + NW; k++) step();
        n_checks++;
        if (log_addr.size() < 5 + NW) begin
            n_fail++;
            $display("[TB] FAIL init_count: got %0d commands required %0d", log_addr.size(), 5 + NW);
        end else begin
`ifdef MPU_WHOAMI_CHECK_EN
            n_checks++;
            if ({log_wr[0], log_addr[0]} !== {1'b0, 8'h75}) begin
                n_fail++;
                $display("[TB] FAIL whoami_cmd: got wr=%b addr=%h required wr=0 addr=75", log_wr[0], log_addr[0]);
            end
`endif
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if ({log_wr[NW + i], log_addr[NW + i], log_data[NW + i]} !== {1'b1, ea[i], ed[i]}) begin
                    n_fail++;
                    $display("[TB] FAIL init_write%0d: got wr=%b %h<-%h required wr=1 %h<-%h",
                             i, log_wr[NW + i], log_addr[NW + i], log_data[NW + i], ea[i], ed[i]);
                end
            end
        end
        for (int k = 0; k < 100 && init_done !== 1'b1; k++) step();
        n_checks++;
        if (init_done !== 1'b1 || cyc !== last_done_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL init_done_time: got init_done=%b at cycle %0d required 1 at cycle %0d", init_done, cyc, last_done_cyc + 1);
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL init_error: got %b required 0", error);
        end
    endtask

    task automatic test_burst_addr();
        logic [15:0] w [7];
        logic [15:0] exp_w;
        int base;
        for (int k = 0; k < 2 * DIV && sample_valid !== 1'b1; k++) step();
        n_checks++;
        if (sample_valid !== 1'b1 || cyc !== last_done_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL sv_latency: got sv=%b at cycle %0d required 1 at cycle %0d", sample_valid, cyc, last_done_cyc + 1);
        end
        base = log_addr.size() - 14;
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if (base < 0 || {log_wr[base + i], log_addr[base + i]} !== {1'b0, 8'(8'h3B + i)}) begin
                n_fail++;
                $display("[TB] FAIL burst_read%0d: got wr=%b addr=%h required wr=0 addr=%h",
                         i, base < 0 ? 1'b0 : log_wr[base + i], base < 0 ? 8'h00 : log_addr[base + i], 8'(8'h3B + i));
            end
        end
        w = '{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
        for (int i = 0; i < 7; i++) begin
            exp_w = {8'(8'h3B + 2 * i), 8'(8'h3C + 2 * i)};
            n_checks++;
            if (w[i] !== exp_w) begin
                n_fail++;
                $display("[TB] FAIL burst_word%0d: got %h required %h", i, w[i], exp_w);
            end
        end
        step();
        n_checks++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sv_width: got %b required 0", sample_valid);
        end
    endtask

    task automatic test_period();
        int s0 = sv_count;
        for (int k = 0; k < 3 * DIV && sv_count < s0 + 2; k++) step();
        n_checks++;
        if (sv_count < s0 + 2 || sv_cyc[$] - sv_cyc[$-1] !== DIV) begin
            n_fail++;
            $display("[TB] FAIL sv_period: got %0d pulses, spacing %0d required spacing %0d",
                     sv_count - s0, sv_cyc.size() > 1 ? sv_cyc[$] - sv_cyc[$-1] : -1, DIV);
        end
    endtask

    task automatic test_random_data();
        logic [15:0] w [7];
        logic [15:0] exp_w;
        addr_mode = 1'b0;
        rand_lat  = 1'b1;
        rand_mem();
        for (int b = 0; b < 3; b++) begin
            step();
            for (int k = 0; k < 2 * DIV && sample_valid !== 1'b1; k++) step();
            w = '{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
            for (int i = 0; i < 7; i++) begin
                exp_w = {mem[8'h3B + 2 * i], mem[8'h3C + 2 * i]};
                n_checks++;
                if (sample_valid !== 1'b1 || w[i] !== exp_w) begin
                    n_fail++;
                    $display("[TB] FAIL rand_word b%0d w%0d: got %h (sv=%b) required %h", b, i, w[i], sample_valid, exp_w);
                end
            end
            rand_mem();
        end
        rand_lat = 1'b0;
    endtask

    task automatic test_timeout();
        int hits [$];
        addr_mode = 1'b1;
        fail_addr = 8'h1B;
        fail_left = 2;
        clear_log();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        for (int k = 0; k < PUP + 400 && init_done !== 1'b1; k++) step();
        for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] == 8'h1B) hits.push_back(i);
        n_checks++;
        if (hits.size() !== 3 || log_addr.size() !== 7 + NW) begin
            n_fail++;
            $display("[TB] FAIL retry_count: got %0d attempts, %0d commands required 3 attempts, %0d commands", hits.size(), log_addr.size(), 7 + NW);
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({log_wr[hits[j]], log_data[hits[j]]} !== {1'b1, 8'h18}) begin
                    n_fail++;
                    $display("[TB] FAIL retry_payload%0d: got wr=%b data=%h required wr=1 data=18", j, log_wr[hits[j]], log_data[hits[j]]);
                end
            end
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (log_cyc[hits[j + 1]] - log_cyc[hits[j]] < TMO || log_cyc[hits[j + 1]] - log_cyc[hits[j]] > TMO + 2) begin
                    n_fail++;
                    $display("[TB] FAIL retry_gap%0d: got %0d cycles required %0d..%0d", j, log_cyc[hits[j + 1]] - log_cyc[hits[j]], TMO, TMO + 2);
                end
            end
        end
        n_checks++;
        if ({init_done, error} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL retry_status: got init_done=%b error=%b required 1 0", init_done, error);
        end
    endtask

    task automatic test_error();
        logic [15:0] held [7];
        logic [15:0] w [7];
        int n0, s0, hits;
        fail_left = 0;
        addr_mode = 1'b0;
        rand_mem();
        for (int k = 0; k < 2 * DIV + 50 && sample_valid !== 1'b1; k++) step();
        for (int i = 0; i < 7; i++) held[i] = {mem[8'h3B + 2 * i], mem[8'h3C + 2 * i]};
        rand_mem();
        clear_log();
        fail_addr = 8'h3F;
        fail_left = 255;
        for (int k = 0; k < DIV + 400 && error !== 1'b1; k++) step();
        hits = 0;
        for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] == 8'h3F) hits++;
        n_checks++;
        if (error !== 1'b1 || hits !== 4) begin
            n_fail++;
            $display("[TB] FAIL error_attempts: got error=%b attempts=%0d required error=1 attempts=4", error, hits);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL error_busy: got %b required 0", busy);
        end
        n0 = log_addr.size();
        s0 = sv_count;
        steps(2 * DIV);
        n_checks++;
        if (log_addr.size() !== n0 || sv_count !== s0 || error !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL error_silent: got %0d new commands, %0d new pulses, error=%b required 0 0 1",
                     log_addr.size() - n0, sv_count - s0, error);
        end
        w = '{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (w[i] !== held[i]) begin
                n_fail++;
                $display("[TB] FAIL error_hold%0d: got %h required %h", i, w[i], held[i]);
            end
        end
        fail_left = 0;
    endtask

    task automatic test_reset_mid_burst();
        int rel;
        addr_mode = 1'b1;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        for (int k = 0; k < PUP + 200 && init_done !== 1'b1; k++) step();
        for (int k = 0; k < 2 * DIV && sample_valid !== 1'b1; k++) step();
        step();
        for (int k = 0; k < DIV + 100 && !(log_addr.size() > 0 && log_addr[$] == 8'h42); k++) step();
        n_checks++;
        if (!(log_addr.size() > 0 && log_addr[$] == 8'h42) || accel_x !== 16'h3B3C) begin
            n_fail++;
            $display("[TB] FAIL midburst_reach: got last addr %h accel_x %h required 42 3b3c",
                     log_addr.size() ? log_addr[$] : 8'h00, accel_x);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({iic_en, write, read, sample_valid, init_done, busy, error, address, write_data} !== 23'h0 ||
            {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'h0) begin
            n_fail++;
            $display("[TB] FAIL midburst_reset: got ctrl %b addr %h data %h accel_x %h gyro_z %h required all zero",
                     {iic_en, write, read, sample_valid, init_done, busy, error}, address, write_data, accel_x, gyro_z);
        end
        clear_log();
        rel = cyc;
        reset = 1'b0;
        for (int k = 0; k < PUP + 200 && log_addr.size() < 5 + NW; k++) step();
        n_checks++;
        if (log_addr.size() < 5 + NW || log_cyc[0] - rel < PUP || log_cyc[0] - rel > PUP + 3) begin
            n_fail++;
            $display("[TB] FAIL midburst_silence: got %0d commands, first after %0d cycles required >=%0d after %0d..%0d",
                     log_addr.size(), log_addr.size() ? log_cyc[0] - rel : -1, 5 + NW, PUP, PUP + 3);
        end else begin
            n_checks++;
            if ({log_addr[NW], log_data[NW], log_addr[NW + 4], log_data[NW + 4]} !== 32'h6B00_1C00) begin
                n_fail++;
                $display("[TB] FAIL midburst_reinit: got %h<-%h .. %h<-%h required 6b<-00 .. 1c<-00",
                         log_addr[NW], log_data[NW], log_addr[NW + 4], log_data[NW + 4]);
            end
        end
        for (int k = 0; k < 100 && init_done !== 1'b1; k++) step();
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midburst_init_done: got %b required 1", init_done);
        end
    endtask

`ifdef MPU_WHOAMI_CHECK_EN
    task automatic test_whoami_bad();
        int writes;
        whoami_val = 8'h70;
        clear_log();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        for (int k = 0; k < PUP + 200 && error !== 1'b1; k++) step();
        steps(20);
        writes = 0;
        for (int i = 0; i < log_wr.size(); i++) if (log_wr[i]) writes++;
        n_checks++;
        if ({error, busy} !== 2'b10 || writes !== 0 || log_addr.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL whoami_bad: got error=%b busy=%b writes=%0d cmds=%0d required 1 0 0 1",
                     error, busy, writes, log_addr.size());
        end
        whoami_val = 8'h68;
    endtask
`endif

    initial begin
        reset = 1'b1;
        $display("[TB] mpu6050_seq bench start");
        test_reset();
        test_init();
        test_burst_addr();
        test_period();
        test_random_data();
        test_timeout();
        test_error();
        test_reset_mid_burst();
`ifdef MPU_WHOAMI_CHECK_EN
        test_whoami_bad();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
